sensor_frame_packer: RTL and testbench

Converts raw sensor bytes popped from the I2C-side FIFO into a printable ASCII frame and streams it into the UART transmitter. The frame is a start character, two uppercase hex characters per data byte, a two-character hex checksum, and CR LF. The block sits between the `FSM_I2C_FIFO` read port and the `uart` TX handshake, in place of raw binary forwarding. It replaces nothing upstream; the UART command FSM only pulses `i_start`.

---
 rtl/sensor_frame_packer.sv | 216 +++++++++++++++++++++
 tb/tb_sensor_frame_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_packer.sv
// Purpose : turns FIFO sensor bytes into an ASCII frame ":HHHH..CC\r\n" streamed to the UART TX handshake.
// Latency : start -> ':' valid next cycle; FIFO pop is combinational in WAIT_BYTE, HI char valid the cycle after the pop.
// Backpr. : each character is held (data and valid stable) until ready; FIFO waits are bounded by TIMEOUT_CYCLES.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start                           frame request pulse (ignored while busy)
//   i_fifo_data_out / _valid_to_extract / o_fifo_data_out_extracted   FIFO head, valid, pop pulse
//   o_uart_send_data / _valid, i_uart_send_data_ready                 UART character handshake
//   o_busy, o_frame_done, o_timeout_err                                status
module sensor_frame_packer #(
    parameter int         BYTES_PER_FRAME = 2,
    parameter logic [7:0] START_CHAR      = 8'h3A,
    parameter int         TIMEOUT_CYCLES  = 26000,
    parameter int         TO_BITS         = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_fifo_data_out,
    input  logic       i_fifo_data_out_valid_to_extract,
    output logic       o_fifo_data_out_extracted,
    output logic [7:0] o_uart_send_data,
    output logic       o_uart_send_valid,
    input  logic       i_uart_send_data_ready,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_timeout_err
);

    typedef enum logic [3:0] {
        IDLE,
        SEND_START,
        WAIT_BYTE,
        SEND_HI,
        SEND_LO,
        SEND_CS_HI,
        SEND_CS_LO,
        SEND_CR,
        SEND_LF
    } state_t;

    localparam logic [4:0]         LAST_IDX = 5'(BYTES_PER_FRAME - 1);
    localparam logic [TO_BITS-1:0] TO_LAST  = TO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         CH_DASH  = 8'h2D;
    localparam logic [7:0]         CH_CR    = 8'h0D;
    localparam logic [7:0]         CH_LF    = 8'h0A;

    state_t               state_q, state_d;
    logic [7:0]           byte_q, byte_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           tx_dat_q, tx_dat_d;
    logic [4:0]           idx_q, idx_d;
    logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;
    logic                 missing_q, missing_d;
    logic                 tx_vld_q, tx_vld_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 pop;
    logic                 xfer;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    assign xfer = tx_vld_q & i_uart_send_data_ready;

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        csum_d    = csum_q;
        tx_dat_d  = tx_dat_q;
        idx_d     = idx_q;
        to_cnt_d  = to_cnt_q;
        missing_d = missing_q;
        tx_vld_d  = tx_vld_q;
        err_d     = err_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    csum_d    = 8'h00;
                    idx_d     = 5'd0;
                    err_d     = 1'b0;
                    missing_d = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = SEND_START;
                    tx_vld_d  = 1'b1;
                    tx_dat_d  = START_CHAR;
                end
            end
            SEND_START: begin
                if (xfer) begin
                    state_d  = WAIT_BYTE;
                    tx_vld_d = 1'b0;
                    to_cnt_d = '0;
                end
            end
            WAIT_BYTE: begin
                // Data has priority over the timeout, so a byte arriving on the last cycle is still taken.
                if (i_fifo_data_out_valid_to_extract) begin
                    pop       = 1'b1;
                    byte_d    = i_fifo_data_out;
                    csum_d    = csum_q + i_fifo_data_out;
                    missing_d = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = SEND_HI;
                    tx_vld_d  = 1'b1;
                    tx_dat_d  = hex_char(i_fifo_data_out[7:4]);
                end else if (to_cnt_q == TO_LAST) begin
                    err_d     = 1'b1;
                    missing_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = SEND_HI;
                    tx_vld_d  = 1'b1;
                    tx_dat_d  = CH_DASH;
                end else begin
                    to_cnt_d  = to_cnt_q + 1'b1;
                end
            end
            SEND_HI: begin
                if (xfer) begin
                    state_d  = SEND_LO;
                    tx_dat_d = missing_q ? CH_DASH : hex_char(byte_q[3:0]);
                end
            end
            SEND_LO: begin
                if (xfer) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d    = idx_q + 5'd1;
                        state_d  = WAIT_BYTE;
                        tx_vld_d = 1'b0;
                        to_cnt_d = '0;
                    end else begin
                        state_d  = SEND_CS_HI;
                        tx_dat_d = hex_char(csum_q[7:4]);
                    end
                end
            end
            SEND_CS_HI: begin
                if (xfer) begin
                    state_d  = SEND_CS_LO;
                    tx_dat_d = hex_char(csum_q[3:0]);
                end
            end
            SEND_CS_LO: begin
                if (xfer) begin
                    state_d  = SEND_CR;
                    tx_dat_d = CH_CR;
                end
            end
            SEND_CR: begin
                if (xfer) begin
                    state_d  = SEND_LF;
                    tx_dat_d = CH_LF;
                end
            end
            SEND_LF: begin
                if (xfer) begin
                    state_d  = IDLE;
                    tx_vld_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_vld_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            byte_q    <= 8'h00;
            csum_q    <= 8'h00;
            tx_dat_q  <= 8'h00;
            idx_q     <= 5'd0;
            to_cnt_q  <= '0;
            missing_q <= 1'b0;
            tx_vld_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            csum_q    <= csum_d;
            tx_dat_q  <= tx_dat_d;
            idx_q     <= idx_d;
            to_cnt_q  <= to_cnt_d;
            missing_q <= missing_d;
            tx_vld_q  <= tx_vld_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // The pop must coincide with the cycle the head byte is sampled; it is masked while reset is applied.
    assign o_fifo_data_out_extracted = pop & ~i_rst;
    assign o_uart_send_data          = tx_dat_q;
    assign o_uart_send_valid         = tx_vld_q;
    assign o_busy                    = busy_q;
    assign o_frame_done              = done_q;
    assign o_timeout_err             = err_q;

endmodule

// File: tb/tb_sensor_frame_packer.sv
module tb_sensor_frame_packer;

    localparam int NB        = 2;
    localparam int TO        = 8;
    localparam int FRAME_LEN = 1 + 2 * NB + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] fifo_dat;
    logic       fifo_vld;
    logic       pop;
    logic [7:0] tx_dat;
    logic       tx_vld;
    logic       tx_rdy;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    sensor_frame_packer #(
        .BYTES_PER_FRAME (NB),
        .START_CHAR      (8'h3A),
        .TIMEOUT_CYCLES  (TO),
        .TO_BITS         (16)
    ) dut (
        .i_clk                            (clk),
        .i_rst                            (rst),
        .i_start                          (start),
        .i_fifo_data_out                  (fifo_dat),
        .i_fifo_data_out_valid_to_extract (fifo_vld),
        .o_fifo_data_out_extracted        (pop),
        .o_uart_send_data                 (tx_dat),
        .o_uart_send_valid                (tx_vld),
        .i_uart_send_data_ready           (tx_rdy),
        .o_busy                           (busy),
        .o_frame_done                     (done),
        .o_timeout_err                    (err)
    );

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        p0;
        logic        p1;
        int          d0;
        int          d1;
        int          rmode;    // 0: ready always, 1: 1 on / 3 off, 2: random
        logic        restart;  // pulse start again while busy
        logic [71:0] exp_str;
        logic        exp_err;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] plan_byte[NB];
    logic       plan_pres[NB];
    int         plan_dly[NB];
    int         plan_rmode;
    logic       plan_restart;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    // Reference: the frame text follows directly from which bytes arrived.
    task automatic build_model(output logic e);
        int sum;
        logic [7:0] s8;
        exp_q.delete();
        sum = 0;
        e = 1'b0;
        exp_q.push_back(8'h3A);
        for (int s = 0; s < NB; s++) begin
            if (plan_pres[s]) begin
                exp_q.push_back(hexc(plan_byte[s][7:4]));
                exp_q.push_back(hexc(plan_byte[s][3:0]));
                sum += int'(plan_byte[s]);
            end else begin
                exp_q.push_back(8'h2D);
                exp_q.push_back(8'h2D);
                e = 1'b1;
            end
        end
        s8 = 8'(sum % 256);
        exp_q.push_back(hexc(s8[7:4]));
        exp_q.push_back(hexc(s8[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Starts at a negedge, runs one frame, ends at a negedge.
    task automatic run_frame(input string tag, input logic exp_err);
        int cyc, slot, wcnt, pops, exp_pops, dones, post, k;
        logic armed, prev_stall, stable_ok, pop_ok, rdy, lf_seen;
        logic [7:0] prev_dat, g;
        got_q.delete();
        armed = 0; slot = 0; wcnt = 0; pops = 0; dones = 0; post = 0; cyc = 0;
        prev_stall = 0; prev_dat = 0; stable_ok = 1; pop_ok = 1; lf_seen = 0;
        exp_pops = 0;
        for (int s = 0; s < NB; s++) if (plan_pres[s]) exp_pops++;
        fifo_vld = 0; tx_rdy = 0; start = 1;
        @(posedge clk); @(negedge clk);
        start = 0;
        check({tag, "/start_vld"}, 32'(tx_vld), 1);
        check({tag, "/start_chr"}, 32'(tx_dat), 32'h3A);
        while (cyc < 2000 && post < 4) begin
            case (plan_rmode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_rdy   = rdy;
            fifo_vld = armed && plan_pres[slot] && (wcnt >= plan_dly[slot]);
            fifo_dat = fifo_vld ? plan_byte[slot] : 8'($urandom);
            start    = plan_restart && (cyc == 5);
            #1;
            if (prev_stall && (!tx_vld || tx_dat != prev_dat)) stable_ok = 0;
            if (pop) begin
                pops++;
                if (!fifo_vld) pop_ok = 0;
                armed = 0;
            end
            if (done) dones++;
            if (armed) wcnt++;
            if (tx_vld && rdy) begin
                got_q.push_back(tx_dat);
                k = got_q.size() - 1;
                if (k == 0) begin
                    armed = 1; slot = 0; wcnt = 0;
                end else if (k >= 2 && k <= 2 * NB - 2 && k % 2 == 0) begin
                    armed = 1; slot = k / 2; wcnt = 0;
                end
                if (got_q.size() >= FRAME_LEN) lf_seen = 1;
            end
            if (lf_seen) post++;
            prev_stall = tx_vld && !rdy;
            prev_dat   = tx_dat;
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        start = 0; tx_rdy = 0; fifo_vld = 0;
        check({tag, "/finished"}, 32'(lf_seen), 1);
        check({tag, "/len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            check($sformatf("%s/chr%0d", tag, i), 32'(g), 32'(exp_q[i]));
        end
        check({tag, "/pops"}, pops, exp_pops);
        check({tag, "/pop_ok"}, 32'(pop_ok), 1);
        check({tag, "/done_cnt"}, dones, 1);
        check({tag, "/stable"}, 32'(stable_ok), 1);
        check({tag, "/err"}, 32'(err), 32'(exp_err));
        check({tag, "/busy_end"}, 32'(busy), 0);
    endtask

    task automatic load_vec(input vec_t v);
        logic [71:0] t;
        plan_byte[0] = v.b0; plan_byte[1] = v.b1;
        plan_pres[0] = v.p0; plan_pres[1] = v.p1;
        plan_dly[0]  = v.d0; plan_dly[1]  = v.d1;
        plan_rmode   = v.rmode;
        plan_restart = v.restart;
        t = v.exp_str;
        exp_q.delete();
        for (int j = 0; j < FRAME_LEN; j++) exp_q.push_back(t[71 - 8 * j -: 8]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        logic e;
        int n, cyc;
        vt[0] = '{8'h19, 8'h80, 1'b1, 1'b1, 0, 0, 0, 1'b0, ":198099\015\012", 1'b0};
        vt[1] = '{8'hAB, 8'hCD, 1'b1, 1'b1, 0, 0, 0, 1'b0, ":ABCD78\015\012", 1'b0};
        vt[2] = '{8'h19, 8'h80, 1'b1, 1'b1, 1, 2, 1, 1'b0, ":198099\015\012", 1'b0};
        vt[3] = '{8'h19, 8'h55, 1'b1, 1'b0, 0, 0, 0, 1'b0, ":19--19\015\012", 1'b1};
        vt[4] = '{8'h00, 8'h00, 1'b1, 1'b1, 7, 7, 2, 1'b0, ":000000\015\012", 1'b0};
        vt[5] = '{8'hFF, 8'h01, 1'b1, 1'b1, 3, 5, 0, 1'b1, ":FF0100\015\012", 1'b0};
        vt[6] = '{8'h00, 8'hFF, 1'b0, 1'b1, 0, 0, 1, 1'b0, ":--FFFF\015\012", 1'b1};
        vt[7] = '{8'h12, 8'h34, 1'b0, 1'b0, 0, 0, 2, 1'b0, ":----00\015\012", 1'b1};

        rst = 1; start = 0; fifo_dat = 0; fifo_vld = 0; tx_rdy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/vld",  32'(tx_vld), 0);
        check("rst/dat",  32'(tx_dat), 0);
        check("rst/pop",  32'(pop), 0);
        check("rst/busy", 32'(busy), 0);
        check("rst/done", 32'(done), 0);
        check("rst/err",  32'(err), 0);
        rst = 0;
        @(posedge clk); @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            load_vec(vt[i]);
            run_frame($sformatf("vec%0d", i), vt[i].exp_err);
        end

        // Reset after the third character transfer.
        fifo_vld = 1; fifo_dat = 8'h19; tx_rdy = 1; start = 1;
        @(posedge clk); @(negedge clk);
        start = 0;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            if (tx_vld) n++;
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check("midrst/xfers", n, 3);
        rst = 1; fifo_vld = 0; tx_rdy = 0;
        @(posedge clk); @(negedge clk);
        check("midrst/vld",  32'(tx_vld), 0);
        check("midrst/busy", 32'(busy), 0);
        rst = 0; tx_rdy = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst/quiet", 32'(tx_vld), 0);
        tx_rdy = 0;
        load_vec(vt[1]);
        run_frame("after_rst", 1'b0);

        // Randomized frames against the reference model.
        for (int r = 0; r < 20; r++) begin
            for (int s = 0; s < NB; s++) begin
                plan_byte[s] = 8'($urandom);
                plan_pres[s] = ($urandom_range(0, 4) != 0);
                plan_dly[s]  = $urandom_range(0, TO - 1);
            end
            plan_rmode   = $urandom_range(0, 2);
            plan_restart = 1'($urandom_range(0, 1));
            build_model(e);
            run_frame($sformatf("rnd%0d", r), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
